// File: rtl/ahbl_sim_ctrl.sv
// AHB-Lite simulation control slave: console byte FIFO, test-exit mailbox and a
// free-running cycle counter, all reached through CPU stores and loads.
module ahbl_sim_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int W_ADDR     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ahbls_hready,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [2:0]        ahbls_hburst,
    input  logic [3:0]        ahbls_hprot,
    input  logic              ahbls_hmastlock,
    input  logic [31:0]       ahbls_hwdata,
    output logic [31:0]       ahbls_hrdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              exit_valid,
    output logic [31:0]       exit_code
);

    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic       write;
        logic [2:0] size;
    } dph_t;

    state_t         state, state_nxt;
    dph_t           dph;
    logic           aph_take;
    logic           dph_done;

    logic           sel_stdout, sel_exit, sel_status, sel_cycles, sel_bad;
    logic           stdout_stall;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr, level;
    logic           fifo_full, fifo_empty, push, pop;

    logic [31:0]    cycles;
    logic [31:0]    status_word;

    // ------------------------------------------------------------------
    // Address phase capture and register decode
    // ------------------------------------------------------------------
    assign aph_take = ahbls_hready && ahbls_htrans[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dph <= '0;
        end else if (aph_take) begin
            dph <= '{addr: ahbls_haddr[7:0], write: ahbls_hwrite, size: ahbls_hsize};
        end
    end

    assign sel_stdout = (dph.addr[7:2] == 6'h00);
    assign sel_exit   = (dph.addr[7:2] == 6'h01);
    assign sel_status = (dph.addr[7:2] == 6'h02);
    assign sel_cycles = (dph.addr[7:2] == 6'h03);
    assign sel_bad    = |dph.addr[7:4];

    // A console write may only wait on a full FIFO; a same-cycle pop frees the slot.
    assign stdout_stall = dph.write && sel_stdout && fifo_full && !pop;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = 1'b0;
        dph_done          = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_DATA: begin
                if (sel_bad) begin
                    ahbls_hready_resp = 1'b0;
                    ahbls_hresp       = 1'b1;
                    state_nxt         = ST_ERR;
                end else if (stdout_stall) begin
                    ahbls_hready_resp = 1'b0;
                end else begin
                    dph_done = 1'b1;
                end
            end
            ST_ERR: ahbls_hresp = 1'b1;
            default: ;
        endcase
        if (ahbls_hready_resp) begin
            state_nxt = aph_take ? ST_DATA : ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO (pointers carry a wrap bit so level is a plain difference)
    // ------------------------------------------------------------------
    assign level      = wr_ptr - rd_ptr;
    assign fifo_full  = (level == LVL_FULL);
    assign fifo_empty = (level == '0);
    assign out_valid  = !fifo_empty;
    assign out_data   = mem[rd_ptr[PTR_W-1:0]];
    assign pop        = out_valid && out_ready;
    assign push       = dph_done && dph.write && sel_stdout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= ahbls_hwdata[7:0];
    end

    // ------------------------------------------------------------------
    // Exit mailbox: first completed write wins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exit_valid <= 1'b0;
            exit_code  <= '0;
        end else if (dph_done && dph.write && sel_exit && !exit_valid) begin
            exit_valid <= 1'b1;
            exit_code  <= ahbls_hwdata;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if (dph_done && dph.write && sel_cycles) begin
            cycles <= ahbls_hwdata;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read data: only live during a completing read of STATUS or CYCLES
    // ------------------------------------------------------------------
    assign status_word = {15'd0, exit_valid, 8'(level), 6'd0, fifo_empty, fifo_full};

    always_comb begin
        ahbls_hrdata = '0;
        if (dph_done && !dph.write) begin
            if (sel_status)      ahbls_hrdata = status_word;
            else if (sel_cycles) ahbls_hrdata = cycles;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{ahbls_haddr[W_ADDR-1:8], ahbls_htrans[0], ahbls_hburst,
                         ahbls_hprot, ahbls_hmastlock, dph.addr[1:0], dph.size};

endmodule

// File: tb/tb_ahbl_sim_ctrl.sv
// Self-checking bench for ahbl_sim_ctrl: directed scenarios plus a randomized
// mix, compared against a queue/arithmetic reference model.
module tb_ahbl_sim_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hready_resp, hresp;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0, hburst = '0;
    logic [3:0]  hprot = '0;
    logic        hmastlock = 1'b0;
    logic [31:0] hwdata = '0, hrdata;
    logic        out_valid, out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        exit_valid;
    logic [31:0] exit_code;

    int          chk_cnt = 0, pass_cnt = 0;
    int          tb_cyc = 0;
    bit          rand_rdy = 1'b0;
    logic [7:0]  popped[$];
    logic [31:0] cyc_ref = '0;
    int          cyc_ref_n = 0;

    ahbl_sim_ctrl #(.FIFO_DEPTH(DEPTH), .W_ADDR(32)) dut (
        .clk(clk), .rst(rst),
        .ahbls_hready(hready_resp), .ahbls_hready_resp(hready_resp), .ahbls_hresp(hresp),
        .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans), .ahbls_hsize(hsize),
        .ahbls_hburst(hburst), .ahbls_hprot(hprot), .ahbls_hmastlock(hmastlock),
        .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .exit_valid(exit_valid), .exit_code(exit_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;
    // Record bytes that will pop on the coming rising edge.
    always @(negedge clk) if (!rst && out_valid && out_ready) popped.push_back(out_data);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [67:0] out_vec();
        return {hready_resp, hresp, hrdata, out_valid, exit_valid, exit_code};
    endfunction
    localparam logic [67:0] RST_VEC = {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0};

    // Counter value the model expects at a negedge sample taken at tb_cyc == n.
    function automatic logic [31:0] cyc_exp(input int n);
        return cyc_ref + 32'(n - cyc_ref_n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // One non-pipelined transfer, starting just after a rising edge.
    task automatic ahb_xfer(input logic [7:0] addr, input bit wr, input logic [31:0] wd,
                            output logic [31:0] rd, output int waits, output bit err,
                            output int smp);
        haddr  = {24'($urandom), addr[7:2], 2'($urandom)};
        hwrite = wr;
        htrans = {1'b1, 1'($urandom)};
        hsize  = 3'($urandom);
        tick();
        htrans = 2'b00;
        hwdata = wd;
        haddr  = $urandom;
        waits  = 0;
        err    = 1'b0;
        rd     = '0;
        smp    = 0;
        forever begin
            @(negedge clk);
            if (hresp) err = 1'b1;
            if (hready_resp) begin
                rd  = hrdata;
                smp = tb_cyc;
                break;
            end
            waits++;
            if (waits > 40) break;
            tick();
        end
        tick();
    endtask

    task automatic start_stalled_write(input logic [7:0] b);
        haddr  = {24'($urandom), 8'h00};
        hwrite = 1'b1;
        htrans = 2'b10;
        tick();
        htrans = 2'b00;
        hwdata = {24'($urandom), b};
        haddr  = $urandom;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int w, n; bit e;
        rst = 1'b1;
        #3;
        chk_cnt++; if (out_vec() !== RST_VEC) $display("FAIL reset_outputs got %h exp %h", out_vec(), RST_VEC); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_ref = '0;
        cyc_ref_n = tb_cyc;
        ahb_xfer(8'h08, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== 32'h2) $display("FAIL reset_status got %h exp %h", rd, 32'h2); else pass_cnt++;
        ahb_xfer(8'h0C, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== cyc_exp(n)) $display("FAIL reset_cycles got %h exp %h", rd, cyc_exp(n)); else pass_cnt++;
    endtask

    task automatic test_stdout();
        logic [31:0] rd; int w, n; bit e;
        logic [7:0] msg [3] = '{8'h41, 8'h42, 8'h43};
        out_ready = 1'b1;
        popped.delete();
        for (int i = 0; i < 3; i++) begin
            ahb_xfer(8'h00, 1'b1, {24'($urandom), msg[i]}, rd, w, e, n);
            chk_cnt++; if (w !== 0 || e || rd !== 0) $display("FAIL stdout_wr%0d waits=%0d err=%0b rdata=%h exp 0/0/0", i, w, e, rd); else pass_cnt++;
        end
        repeat (3) tick();
        chk_cnt++;
        if (popped.size() != 3 || popped[0] !== 8'h41 || popped[1] !== 8'h42 || popped[2] !== 8'h43)
            $display("FAIL stdout_order got %0d bytes first=%h exp 41 42 43", popped.size(), popped.size() ? popped[0] : 8'hxx);
        else pass_cnt++;
        ahb_xfer(8'h08, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== 32'h2 || out_valid !== 1'b0) $display("FAIL stdout_empty status=%h out_valid=%b exp 2/0", rd, out_valid); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        logic [31:0] rd; int w, n; bit e; int bad;
        logic [7:0] b [9];
        out_ready = 1'b0;
        popped.delete();
        foreach (b[i]) b[i] = 8'($urandom);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            ahb_xfer(8'h00, 1'b1, {24'($urandom), b[i]}, rd, w, e, n);
            if (w != 0 || e) bad++;
        end
        chk_cnt++; if (bad != 0) $display("FAIL full_fill stalled_writes=%0d exp 0", bad); else pass_cnt++;
        start_stalled_write(b[8]);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_cnt++; if (hready_resp !== 1'b0 || hresp !== 1'b0) $display("FAIL full_stall%0d hready_resp=%b hresp=%b exp 0/0", c, hready_resp, hresp); else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (hready_resp !== 1'b1) $display("FAIL full_release hready_resp=%b exp 1", hready_resp); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        ahb_xfer(8'h08, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== 32'h0000_0801) $display("FAIL full_status got %h exp %h", rd, 32'h0000_0801); else pass_cnt++;
        out_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 9; i++) if (i >= popped.size() || popped[i] !== b[i]) bad++;
        chk_cnt++; if (bad != 0 || popped.size() != 9) $display("FAIL full_order got %0d bytes %0d wrong exp 9/0", popped.size(), bad); else pass_cnt++;
    endtask

    task automatic test_exit();
        logic [31:0] rd; int w, n; bit e;
        ahb_xfer(8'h04, 1'b1, 32'hDEAD_0001, rd, w, e, n);
        chk_cnt++; if (rd !== 0 || w != 0) $display("FAIL exit_wr rdata=%h waits=%0d exp 0/0", rd, w); else pass_cnt++;
        ahb_xfer(8'h04, 1'b1, 32'h0000_0005, rd, w, e, n);
        chk_cnt++; if (exit_valid !== 1'b1 || exit_code !== 32'hDEAD_0001) $display("FAIL exit_latch valid=%b code=%h exp 1/deAD0001", exit_valid, exit_code); else pass_cnt++;
        ahb_xfer(8'h08, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== 32'h0001_0002) $display("FAIL exit_status got %h exp %h", rd, 32'h0001_0002); else pass_cnt++;
        ahb_xfer(8'h04, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== 0) $display("FAIL exit_rd got %h exp 0", rd); else pass_cnt++;
    endtask

    task automatic test_cycles();
        logic [31:0] rd; int w, n; bit e;
        ahb_xfer(8'h0C, 1'b1, 32'hFFFF_FFFE, rd, w, e, n);
        cyc_ref = 32'hFFFF_FFFE;
        cyc_ref_n = n + 1;
        chk_cnt++; if (rd !== 0 || w != 0) $display("FAIL cycles_wr rdata=%h waits=%0d exp 0/0", rd, w); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(1, 6)) tick();
            ahb_xfer(8'h0C, 1'b0, '0, rd, w, e, n);
            chk_cnt++; if (rd !== cyc_exp(n)) $display("FAIL cycles_rd%0d got %h exp %h", k, rd, cyc_exp(n)); else pass_cnt++;
        end
    endtask

    task automatic test_error();
        logic [31:0] rd; int w, n; bit e;
        logic [7:0] bad_off;
        for (int it = 0; it < 2; it++) begin
            bad_off = (it == 0) ? 8'h10 : 8'($urandom_range(4, 63) << 2);
            haddr  = {24'($urandom), bad_off};
            hwrite = (it == 0) ? 1'b1 : 1'($urandom);
            htrans = 2'b10;
            tick();
            htrans = 2'b00;
            hwdata = $urandom;
            haddr  = $urandom;
            @(negedge clk);
            chk_cnt++; if ({hready_resp, hresp} !== 2'b01 || hrdata !== 0) $display("FAIL err%0d_c1 hready_resp/hresp=%b rdata=%h exp 01/0", it, {hready_resp, hresp}, hrdata); else pass_cnt++;
            tick();
            @(negedge clk);
            chk_cnt++; if ({hready_resp, hresp} !== 2'b11) $display("FAIL err%0d_c2 hready_resp/hresp=%b exp 11", it, {hready_resp, hresp}); else pass_cnt++;
            tick();
            @(negedge clk);
            chk_cnt++; if ({hready_resp, hresp} !== 2'b10) $display("FAIL err%0d_after hready_resp/hresp=%b exp 10", it, {hready_resp, hresp}); else pass_cnt++;
            tick();
        end
        // IDLE and BUSY at a bad offset must stay OKAY with no wait state.
        haddr  = 32'h0000_0010;
        hwrite = 1'b1;
        for (int c = 0; c < 4; c++) begin
            htrans = {1'b0, 1'(c)};
            tick();
            @(negedge clk);
            chk_cnt++; if ({hready_resp, hresp} !== 2'b10) $display("FAIL idle_busy%0d hready_resp/hresp=%b exp 10", c, {hready_resp, hresp}); else pass_cnt++;
        end
        htrans = 2'b00;
        tick();
        ahb_xfer(8'h08, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== 32'h0001_0002 || exit_code !== 32'hDEAD_0001) $display("FAIL err_nochange status=%h code=%h exp 00010002/dead0001", rd, exit_code); else pass_cnt++;
        ahb_xfer(8'h0C, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== cyc_exp(n)) $display("FAIL err_cycles got %h exp %h", rd, cyc_exp(n)); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [31:0] rd, d; int w, n, lvl, bad; bit e;
        popped.delete();
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int op;
            op = $urandom_range(0, 9);
            d  = $urandom;
            if (op <= 5) begin
                ahb_xfer(8'h00, 1'b1, d, rd, w, e, n);
                exp_q.push_back(d[7:0]);
                chk_cnt++; if (w > 40 || e || rd !== 0) $display("FAIL rnd_stdout%0d waits=%0d err=%0b rdata=%h", i, w, e, rd); else pass_cnt++;
            end else if (op == 6) begin
                ahb_xfer(8'h0C, 1'b1, d, rd, w, e, n);
                cyc_ref = d;
                cyc_ref_n = n + 1;
                chk_cnt++; if (w != 0 || e) $display("FAIL rnd_cycwr%0d waits=%0d err=%0b exp 0/0", i, w, e); else pass_cnt++;
            end else if (op == 7) begin
                ahb_xfer(8'h0C, 1'b0, '0, rd, w, e, n);
                chk_cnt++; if (rd !== cyc_exp(n) || w != 0) $display("FAIL rnd_cycrd%0d got %h exp %h", i, rd, cyc_exp(n)); else pass_cnt++;
            end else if (op == 8) begin
                ahb_xfer(8'h08, 1'b0, '0, rd, w, e, n);
                lvl = int'(rd[15:8]);
                chk_cnt++;
                if (rd[31:17] !== 0 || rd[7:2] !== 0 || rd[16] !== 1'b1 || lvl > DEPTH ||
                    rd[0] !== (lvl == DEPTH) || rd[1] !== (lvl == 0))
                    $display("FAIL rnd_status%0d got %h (inconsistent fields)", i, rd);
                else pass_cnt++;
            end else begin
                repeat ($urandom_range(1, 4)) tick();
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 4) tick();
        out_ready = 1'b0;
        bad = 0;
        foreach (exp_q[i]) if (i >= popped.size() || popped[i] !== exp_q[i]) bad++;
        chk_cnt++; if (bad != 0 || popped.size() != exp_q.size()) $display("FAIL rnd_order got %0d bytes %0d wrong exp %0d/0", popped.size(), bad, exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_stall();
        logic [31:0] rd; int w, n; bit e;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ahb_xfer(8'h00, 1'b1, $urandom, rd, w, e, n);
        popped.delete();
        start_stalled_write(8'h5A);
        @(negedge clk);
        chk_cnt++; if (hready_resp !== 1'b0) $display("FAIL rst_stall hready_resp=%b exp 0", hready_resp); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        chk_cnt++; if (out_vec() !== RST_VEC) $display("FAIL rst_async got %h exp %h", out_vec(), RST_VEC); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_ref = '0;
        cyc_ref_n = tb_cyc;
        ahb_xfer(8'h08, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== 32'h2 || out_valid !== 1'b0) $display("FAIL rst_fifo status=%h out_valid=%b exp 2/0", rd, out_valid); else pass_cnt++;
        ahb_xfer(8'h0C, 1'b0, '0, rd, w, e, n);
        chk_cnt++; if (rd !== cyc_exp(n)) $display("FAIL rst_cycles got %h exp %h", rd, cyc_exp(n)); else pass_cnt++;
        chk_cnt++; if (popped.size() != 0) $display("FAIL rst_nopop got %0d bytes exp 0", popped.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stdout();
        test_fifo_full();
        test_exit();
        test_cycles();
        test_error();
        test_random();
        test_reset_stall();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
